// File: rtl/cache_ctrl_4way.sv
// cache_ctrl_4way: control FSM for a 4-way set-associative L1 cache.
// Handles hit/miss sequencing, dirty-victim writeback and line fill. It also
// owns the per-set tree pseudo-LRU bits that choose the victim way on a miss.
module cache_ctrl_4way #(
    parameter int SET_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [SET_W-1:0] cpu_index,
    output logic             cpu_resp,
    input  logic [3:0]       hit,
    input  logic [3:0]       dirty,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [1:0]       way_sel,
    output logic             load_tag,
    output logic             load_data,
    output logic             data_src_mem,
    output logic             set_dirty,
    output logic             clr_dirty,
    output logic             addr_sel
);

    localparam int NUM_SETS = 2 ** SET_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] lru_q [NUM_SETS];
    logic [2:0] lru_d [NUM_SETS];
    logic [1:0] victim_q, victim_d;

    logic [2:0] lru_cur;
    logic       hit_any;
    logic [1:0] hit_way;
    logic [1:0] victim_way;

    // Marks way w as most recently used: the root and the pair bit are
    // pointed away from w so the next victim comes from elsewhere.
    function automatic logic [2:0] lru_touch(input logic [2:0] cur, input logic [1:0] w);
        logic [2:0] nxt;
        case (w)
            2'd0:    nxt = {1'b1, 1'b1, cur[0]};
            2'd1:    nxt = {1'b1, 1'b0, cur[0]};
            2'd2:    nxt = {1'b0, cur[1], 1'b1};
            default: nxt = {1'b0, cur[1], 1'b0};
        endcase
        return nxt;
    endfunction

    // Decode the indexed set: lowest hitting way and the LRU-selected victim.
    always_comb begin
        lru_cur = lru_q[cpu_index];
        hit_any = |hit;
        if (hit[0])      hit_way = 2'd0;
        else if (hit[1]) hit_way = 2'd1;
        else if (hit[2]) hit_way = 2'd2;
        else             hit_way = 2'd3;
        if (!lru_cur[2]) victim_way = lru_cur[1] ? 2'd1 : 2'd0;
        else             victim_way = lru_cur[0] ? 2'd3 : 2'd2;
    end

    // State, LRU array and latched victim; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            victim_q <= 2'd0;
            for (int i = 0; i < NUM_SETS; i++) begin
                lru_q[i] <= 3'b000;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            for (int i = 0; i < NUM_SETS; i++) begin
                lru_q[i] <= lru_d[i];
            end
        end
    end

    // Next state; LRU only moves on hits, victim is captured on a miss.
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        for (int i = 0; i < NUM_SETS; i++) begin
            lru_d[i] = lru_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (cpu_read || cpu_write) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (hit_any) begin
                    lru_d[cpu_index] = lru_touch(lru_cur, hit_way);
                    state_d          = S_IDLE;
                end else begin
                    victim_d = victim_way;
                    state_d  = dirty[victim_way] ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                if (pmem_resp) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                if (pmem_resp) state_d = S_COMPARE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and handshake controls, all low unless the state calls for them.
    always_comb begin
        cpu_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        way_sel      = 2'd0;
        load_tag     = 1'b0;
        load_data    = 1'b0;
        data_src_mem = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        addr_sel     = 1'b0;
        case (state_q)
            S_COMPARE: begin
                if (hit_any) begin
                    cpu_resp = 1'b1;
                    way_sel  = hit_way;
                    if (cpu_write) begin
                        load_data = 1'b1;
                        set_dirty = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                way_sel    = victim_q;
            end
            S_ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    load_tag     = 1'b1;
                    load_data    = 1'b1;
                    data_src_mem = 1'b1;
                    clr_dirty    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_4way.sv
// Self-checking bench for cache_ctrl_4way: a transaction-level model of the
// controller and its tree pseudo-LRU is compared against the DUT every cycle,
// and directed transactions pin victim choices with hand-derived values.
module tb_cache_ctrl_4way;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_read, cpu_write;
    logic [2:0] cpu_index;
    logic       cpu_resp;
    logic [3:0] hit, dirty;
    logic       pmem_read, pmem_write, pmem_resp;
    logic [1:0] way_sel;
    logic       load_tag, load_data, data_src_mem, set_dirty, clr_dirty, addr_sel;

    int checks = 0;
    int failures = 0;

    int respCycle, wbWay, allocWay, wrWay;

    cache_ctrl_4way #(.SET_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_index(cpu_index),
        .cpu_resp(cpu_resp), .hit(hit), .dirty(dirty),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .way_sel(way_sel), .load_tag(load_tag), .load_data(load_data),
        .data_src_mem(data_src_mem), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
        .addr_sel(addr_sel)
    );

    always #5 clk = ~clk;

    // Reference model: what the controller is doing, per-set LRU tree, held victim.
    typedef enum {M_IDLE, M_CMP, M_WB, M_ALLOC} mphase_t;
    mphase_t    mPhase;
    logic [2:0] mLru [8];
    logic [1:0] mVictim;

    function automatic logic [1:0] firstHit(input logic [3:0] h);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 3; i >= 0; i--) if (h[i]) w = 2'(i);
        return w;
    endfunction

    // Follow the tree: root selects the pair, the pair bit selects the way.
    function automatic logic [1:0] treeVictim(input logic [2:0] t);
        return t[2] ? {1'b1, t[0]} : {1'b0, t[1]};
    endfunction

    // Point the root away from the accessed pair and the pair bit away from the way.
    function automatic logic [2:0] treeTouch(input logic [2:0] t, input logic [1:0] w);
        logic [2:0] n;
        n = t;
        n[2] = ~w[1];
        if (w[1]) n[0] = ~w[0];
        else      n[1] = ~w[0];
        return n;
    endfunction

    // Advance the model at each clock edge, or clear it on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase  <= M_IDLE;
            mVictim <= 2'd0;
            for (int i = 0; i < 8; i++) mLru[i] <= 3'b000;
        end else begin
            case (mPhase)
                M_IDLE: if (cpu_read || cpu_write) mPhase <= M_CMP;
                M_CMP: begin
                    if (|hit) begin
                        mLru[cpu_index] <= treeTouch(mLru[cpu_index], firstHit(hit));
                        mPhase <= M_IDLE;
                    end else begin
                        mVictim <= treeVictim(mLru[cpu_index]);
                        mPhase  <= dirty[treeVictim(mLru[cpu_index])] ? M_WB : M_ALLOC;
                    end
                end
                M_WB:    if (pmem_resp) mPhase <= M_ALLOC;
                default: if (pmem_resp) mPhase <= M_CMP;
            endcase
        end
    end

    // Compare every output against the model on each falling edge outside reset.
    always @(negedge clk) begin
        logic [8:0] expVec, actVec;
        logic [1:0] expWay;
        logic       wayMatters;
        if (!rst) begin
            expVec = '0;
            expWay = 2'd0;
            wayMatters = 1'b0;
            case (mPhase)
                M_CMP: if (|hit) begin
                    expVec[8] = 1'b1;
                    if (cpu_write) begin
                        expVec[4] = 1'b1;
                        expVec[2] = 1'b1;
                        expWay = firstHit(hit);
                        wayMatters = 1'b1;
                    end
                end
                M_WB: begin
                    expVec[6] = 1'b1;
                    expVec[0] = 1'b1;
                    expWay = mVictim;
                    wayMatters = 1'b1;
                end
                M_ALLOC: begin
                    expVec[7] = 1'b1;
                    expWay = mVictim;
                    wayMatters = 1'b1;
                    if (pmem_resp) expVec[5:1] = 5'b11101;
                end
                default: ;
            endcase
            actVec = {cpu_resp, pmem_read, pmem_write, load_tag, load_data,
                      data_src_mem, set_dirty, clr_dirty, addr_sel};
            checks++;
            if (actVec !== expVec) begin
                failures++;
                $display("[TB] FAIL outputs t=%0t got %b expected %b", $time, actVec, expVec);
            end
            if (wayMatters) begin
                checks++;
                if (way_sel !== expWay) begin
                    failures++;
                    $display("[TB] FAIL way_sel t=%0t got %0d expected %0d", $time, way_sel, expWay);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One CPU request, emulating the datapath and a memory with two-cycle latency.
    task automatic applyStimulus(input bit wr, input bit both, input logic [2:0] idx,
                                 input logic [3:0] h, input logic [3:0] d);
        logic r, lt, pr, pw;
        logic [1:0] ws;
        int busy;
        bit done;
        cpu_read  = !wr || both;
        cpu_write = wr;
        cpu_index = idx;
        hit       = h;
        dirty     = d;
        pmem_resp = 1'b0;
        respCycle = 0; wbWay = -1; allocWay = -1; wrWay = -1;
        busy = 0; done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            r = cpu_resp; lt = load_tag; ws = way_sel; pr = pmem_read; pw = pmem_write;
            if (pw && wbWay < 0) wbWay = int'(ws);
            if (pr && allocWay < 0) allocWay = int'(ws);
            if (r && load_data) wrWay = int'(ws);
            if (r) respCycle = c;
            @(posedge clk);
            #1;
            if (r) begin
                cpu_read = 1'b0; cpu_write = 1'b0; hit = 4'b0000; done = 1'b1;
            end
            if (lt) begin
                hit = 4'b0001 << ws;
                dirty[ws] = 1'b0;
            end
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                busy = 0;
            end else if (pw || pr) begin
                busy++;
                if (busy == 2) pmem_resp = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout idx=%0d no cpu_resp within 40 cycles", idx);
            cpu_read = 1'b0; cpu_write = 1'b0; pmem_resp = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_index = 3'd0;
        hit = 4'b0000; dirty = 4'b0000; pmem_resp = 1'b0;
        #12;
        checkOutput("reset_outputs", {23'd0, cpu_resp, pmem_read, pmem_write, load_tag, load_data,
                    data_src_mem, set_dirty, clr_dirty, addr_sel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] read hit set 2");
        applyStimulus(1'b0, 1'b0, 3'd2, 4'b0100, 4'b0000);
        checkOutput("hit_latency", respCycle, 2);
        checkOutput("hit_no_pmem", allocWay + wbWay, -2);
        checkOutput("lru2_after_w2", mLru[2], 3'b001);

        $display("[TB] read miss set 0");
        applyStimulus(1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000);
        checkOutput("miss0_alloc_way", allocWay, 0);
        checkOutput("miss0_no_wb", wbWay, -1);
        checkOutput("lru0_after_w0", mLru[0], 3'b110);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000);
        checkOutput("miss0b_alloc_way", allocWay, 2);

        $display("[TB] LRU walk on set 5");
        applyStimulus(1'b0, 1'b0, 3'd5, 4'b0010, 4'b0000);
        checkOutput("lru5_after_w1", mLru[5], 3'b100);
        applyStimulus(1'b1, 1'b0, 3'd5, 4'b0000, 4'b0001);
        checkOutput("clean_victim_alloc", allocWay, 2);
        checkOutput("clean_victim_no_wb", wbWay, -1);
        applyStimulus(1'b1, 1'b0, 3'd5, 4'b0000, 4'b0001);
        checkOutput("dirty_victim_wb", wbWay, 0);
        checkOutput("dirty_victim_alloc", allocWay, 0);
        applyStimulus(1'b1, 1'b0, 3'd5, 4'b1000, 4'b0000);
        checkOutput("write_hit_way3", wrWay, 3);
        checkOutput("lru5_after_w3", mLru[5], 3'b010);
        applyStimulus(1'b0, 1'b0, 3'd5, 4'b0000, 4'b0000);
        checkOutput("after_w3_victim", allocWay, 1);

        $display("[TB] multi-hit and request precedence on set 3");
        applyStimulus(1'b1, 1'b1, 3'd3, 4'b0110, 4'b0000);
        checkOutput("multi_hit_way1", wrWay, 1);
        applyStimulus(1'b0, 1'b0, 3'd3, 4'b0000, 4'b0000);
        checkOutput("after_w1_victim", allocWay, 2);

        $display("[TB] stray pmem_resp while idle");
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd2, 4'b0001, 4'b0000);
        checkOutput("stray_resp_latency", respCycle, 2);

        $display("[TB] reset during writeback");
        cpu_write = 1'b1; cpu_index = 3'd5; hit = 4'b0000; dirty = 4'b1111;
        for (int c = 0; c < 10 && !pmem_write; c++) @(negedge clk);
        checkOutput("wb_reached", pmem_write, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_drops_pmem_write", pmem_write, 0);
        checkOutput("rst_drops_addr_sel", addr_sel, 0);
        cpu_write = 1'b0; dirty = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd5, 4'b0000, 4'b0000);
        checkOutput("rst_lru5_victim", allocWay, 0);
        applyStimulus(1'b0, 1'b0, 3'd3, 4'b0000, 4'b0000);
        checkOutput("rst_lru3_victim", allocWay, 0);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
